// File: rtl/contador_pops_if.sv
// Pop/report bus for contador_pops: per-FIFO pop strobes, idle flag,
// count-read request and the registered count report.
interface contador_pops_if #(
    parameter int unsigned CNT_W = 5
);
    logic [3:0]       pop;
    logic             idle;
    logic             req;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cuenta;
    logic             valid;

    modport master (
        output pop, idle, req, idx,
        input  cuenta, valid
    );

    modport slave (
        input  pop, idle, req, idx,
        output cuenta, valid
    );
endinterface

// File: rtl/contador_pops.sv
// Four wrapping pop counters, one per FIFO, whose values can be read back
// through a one-cycle-latency request port while the system is idle.
module contador_pops #(
    parameter int unsigned CNT_W = 5
) (
    input logic            clk,
    input logic            reset,
    contador_pops_if.slave bus
);
    localparam int unsigned N_FIFO = 4;

    typedef enum logic [1:0] {
        S_RESET    = 2'd0,
        S_CONTANDO = 2'd1,
        S_REPORTE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt [N_FIFO];
    logic             service_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Next state; a request is serviced whenever the current state is REPORTE,
    // even if idle drops in that same cycle.
    always_comb begin
        next_state = state;
        service_c  = 1'b0;
        case (state)
            S_RESET: begin
                next_state = S_CONTANDO;
            end
            S_CONTANDO: begin
                if (bus.idle) begin
                    next_state = S_REPORTE;
                end
            end
            S_REPORTE: begin
                service_c = bus.req;
                if (!bus.idle) begin
                    next_state = S_CONTANDO;
                end
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    // Pop counters count in every state and wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_FIFO; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_FIFO; i++) begin
                if (bus.pop[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Report register: samples the pre-increment count of the selected FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cuenta <= '0;
            bus.valid  <= 1'b0;
        end else begin
            bus.valid <= service_c;
            if (service_c) begin
                bus.cuenta <= cnt[bus.idx];
            end
        end
    end
endmodule

// File: tb/tb_contador_pops.sv
// Directed bench for contador_pops: a reference model pushes the expected
// report for every driven cycle and the value is popped after the clock edge.
module tb_contador_pops;
    localparam int unsigned CNT_W = 5;

    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] cuenta;
    } exp_t;

    logic clk;
    logic reset;

    contador_pops_if #(.CNT_W(CNT_W)) bus ();

    contador_pops #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    exp_t sb_q[$];

    // Reference model state: 0 = RESET, 1 = CONTANDO, 2 = REPORTE
    int               m_state = 0;
    logic [CNT_W-1:0] m_cnt [4];
    logic [CNT_W-1:0] m_cuenta = '0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst_v, input logic [3:0] p, input logic idl,
                        input logic rq, input logic [1:0] ix);
        exp_t e;
        exp_t got_e;
        reset    = rst_v;
        bus.pop  = p;
        bus.idle = idl;
        bus.req  = rq;
        bus.idx  = ix;
        if (rst_v) begin
            e.valid  = 1'b0;
            e.cuenta = '0;
            m_state  = 0;
            m_cuenta = '0;
            for (int i = 0; i < 4; i++) m_cnt[i] = '0;
        end else begin
            if (m_state == 2 && rq) begin
                e.valid  = 1'b1;
                e.cuenta = m_cnt[ix];
                m_cuenta = m_cnt[ix];
            end else begin
                e.valid  = 1'b0;
                e.cuenta = m_cuenta;
            end
            if (m_state == 0) m_state = 1;
            else              m_state = idl ? 2 : 1;
            for (int i = 0; i < 4; i++) begin
                if (p[i]) m_cnt[i] = m_cnt[i] + CNT_W'(1);
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        got_e = sb_q.pop_front();
        check($sformatf("valid@%0d", step_no), 8'(bus.valid), 8'(got_e.valid));
        check($sformatf("cuenta@%0d", step_no), 8'(bus.cuenta), 8'(got_e.cuenta));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_cnt[i] = '0;
        reset    = 1'b1;
        bus.pop  = '0;
        bus.idle = 1'b0;
        bus.req  = 1'b0;
        bus.idx  = '0;

        // Reset with pops and req asserted: both ignored
        step(1, 4'b1111, 1, 1, 0);
        step(1, 4'b0000, 0, 0, 0);
        check("reset_valid", 8'(bus.valid), 8'd0);
        check("reset_cuenta", 8'(bus.cuenta), 8'd0);

        // Basic counting and back-to-back reads
        repeat (3) step(0, 4'b0001, 0, 0, 0);
        step(0, 4'b0100, 0, 0, 0);
        step(0, 4'b0000, 1, 0, 0);
        step(0, 4'b0000, 1, 1, 0);
        check("r28_idx0_valid", 8'(bus.valid), 8'd1);
        check("r28_idx0_cuenta", 8'(bus.cuenta), 8'd3);
        step(0, 4'b0000, 1, 1, 2);
        check("r28_idx2_valid", 8'(bus.valid), 8'd1);
        check("r28_idx2_cuenta", 8'(bus.cuenta), 8'd1);
        step(0, 4'b0000, 1, 0, 0);
        check("r28_hold_valid", 8'(bus.valid), 8'd0);
        check("r28_hold_cuenta", 8'(bus.cuenta), 8'd1);

        // Wrap of a counter
        step(1, 4'b0000, 0, 0, 0);
        repeat (32) step(0, 4'b0010, 0, 0, 0);
        step(0, 4'b0000, 1, 0, 0);
        step(0, 4'b0000, 1, 1, 1);
        check("r29_wrap_valid", 8'(bus.valid), 8'd1);
        check("r29_wrap_cuenta", 8'(bus.cuenta), 8'd0);
        step(0, 4'b0010, 0, 0, 0);
        step(0, 4'b0000, 1, 0, 0);
        step(0, 4'b0000, 1, 1, 1);
        check("r29_33_cuenta", 8'(bus.cuenta), 8'd1);

        // Request outside REPORTE is dropped
        step(0, 4'b0000, 0, 0, 0);
        step(0, 4'b0000, 0, 1, 0);
        check("r30_drop_valid", 8'(bus.valid), 8'd0);
        check("r30_drop_cuenta", 8'(bus.cuenta), 8'd1);
        step(0, 4'b0000, 1, 0, 0);
        step(0, 4'b0000, 1, 1, 0);
        check("r30_ok_valid", 8'(bus.valid), 8'd1);
        check("r30_ok_cuenta", 8'(bus.cuenta), 8'd0);

        // idle falling with req in REPORTE is still serviced
        step(0, 4'b0000, 0, 1, 1);
        check("r24_valid", 8'(bus.valid), 8'd1);
        check("r24_cuenta", 8'(bus.cuenta), 8'd1);
        step(0, 4'b0000, 0, 1, 1);
        check("r24_after_valid", 8'(bus.valid), 8'd0);

        // Pop and read of the same FIFO in one cycle
        step(1, 4'b0000, 0, 0, 0);
        repeat (4) step(0, 4'b1000, 0, 0, 0);
        step(0, 4'b0000, 1, 0, 0);
        step(0, 4'b1000, 1, 1, 3);
        check("r31_pre_cuenta", 8'(bus.cuenta), 8'd4);
        step(0, 4'b0000, 1, 1, 3);
        check("r31_post_cuenta", 8'(bus.cuenta), 8'd5);

        // Reset mid-operation with req pending in REPORTE
        repeat (5) step(0, 4'b1111, 1, 0, 0);
        step(1, 4'b1111, 1, 1, 3);
        check("r32_rst_valid", 8'(bus.valid), 8'd0);
        check("r32_rst_cuenta", 8'(bus.cuenta), 8'd0);
        step(0, 4'b0000, 1, 1, 0);
        check("r32_resetstate_valid", 8'(bus.valid), 8'd0);
        step(0, 4'b0000, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b0000, 1, 1, 2'(i));
            check($sformatf("r32_idx%0d_valid", i), 8'(bus.valid), 8'd1);
            check($sformatf("r32_idx%0d_cuenta", i), 8'(bus.cuenta), 8'd0);
        end

        // Randomised tail against the model
        for (int k = 0; k < 200; k++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, 4'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom), 2'($urandom));
        end

        check("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/contador_pops.md
CONTADOR_POPS -- requirements
Module: contador_pops

Interface
REQ-001 Parameter CNT_W, default 5: width of each pop counter and of the cuenta output.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 pop  input  4  one pop strobe per FIFO (bit i = FIFO i); each asserted bit is one read for that cycle.
REQ-005 idle  input  1  high when the system has no FIFO traffic pending; counts may be reported only while idle.
REQ-006 req  input  1  count-read request, one request per cycle asserted.
REQ-007 idx  input  2  FIFO selector for req, sampled in the same cycle as req.
REQ-008 cuenta  output  CNT_W  reported pop count of the FIFO selected by idx; registered.
REQ-009 valid  output  1  high for exactly one cycle when cuenta carries a reported count.

Function
REQ-010 The block SHALL hold four independent CNT_W-bit pop counters, cnt[0..3], one per pop bit.
REQ-011 Each rising edge with pop[i]=1 and reset=0 SHALL increment cnt[i] by 1, regardless of FSM state.
REQ-012 Counters SHALL wrap modulo 2^CNT_W: 31 + 1 = 0 for CNT_W=5; no saturation, no overflow flag.
REQ-013 Multiple pop bits high in one cycle SHALL each increment their own counter in that cycle.
REQ-014 The FSM SHALL have three states: RESET, CONTANDO, REPORTE.
REQ-015 RESET: entered whenever reset=1; exits to CONTANDO on the first edge with reset=0.
REQ-016 CONTANDO -> REPORTE on an edge with idle=1; otherwise stays in CONTANDO.
REQ-017 REPORTE -> CONTANDO on an edge with idle=0; otherwise stays in REPORTE.
REQ-018 In REPORTE, an edge with req=1 SHALL drive cuenta <= cnt[idx] (value before any increment in that same cycle) and valid <= 1.
REQ-019 Latency: cuenta/valid SHALL appear one cycle after the req cycle.
REQ-020 An edge with req=0, or in any state other than REPORTE, SHALL drive valid <= 0; cuenta SHALL hold its last value.
REQ-021 A req issued outside REPORTE SHALL be dropped; it is not queued.
REQ-022 req held high for N consecutive cycles in REPORTE SHALL produce N consecutive valid pulses, each using that cycle's idx.
REQ-023 Reading a counter SHALL NOT modify it; a pop and a read of the same FIFO in one cycle SHALL report the pre-pop value and still increment.
REQ-024 If idle falls in a cycle with req=1 while in REPORTE, the request SHALL be serviced, because the state at that edge is REPORTE.

Reset
REQ-025 While reset=1: all cnt[i]=0, cuenta=0, valid=0, state=RESET.
REQ-026 Pop strobes and req asserted while reset=1 SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard all counts on the next edge, with no partial report.

Verification
REQ-028 Reset, then 3 pops on bit 0, 1 on bit 2, then idle=1; req with idx=0 then idx=2 -> cuenta=3, valid=1; then cuenta=2'd1, valid=1, on consecutive cycles.
REQ-029 32 pops on bit 1, idle, req idx=1 -> cuenta=0 (wrap); 33 pops -> cuenta=1.
REQ-030 With idle=0, req=1 with idx=0 -> valid stays 0 and cuenta is unchanged; after idle=1 the same req -> valid=1.
REQ-031 In REPORTE with cnt[3]=4, pop[3]=1 and req idx=3 in the same cycle -> cuenta=4; the next req idx=3 -> cuenta=5.
REQ-032 pop=4'b1111 for 5 cycles, then reset=1 for one cycle, then idle with req on each idx -> every cuenta=0; valid=0 during reset.
REQ-033 Compare the behavioral and synthesized netlists cycle-by-cycle on all scenarios -> cuenta and valid identical every cycle.
